// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ll/sc unit: FSM states, sc result codes
// and the word-address helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LL_MEM = 2'd1,
    SC_MEM = 2'd2,
    RESP   = 2'd3
  } llsc_state_e;

  localparam logic SC_SUCCESS = 1'b1;
  localparam logic SC_FAIL    = 1'b0;

  localparam int MAX_ADDR_W = 64;

  function automatic logic [MAX_ADDR_W-1:0] word_addr(
    input logic [MAX_ADDR_W-1:0] a
  );
    return {a[MAX_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/link_reg.sv
// Link state (bit + word address) with clear/snoop/set priority.
// Snoop ports exist only when LLSC_SNOOP_EN is defined.
module link_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LLSC_SNOOP_EN
  input  logic              snoop_valid_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
`endif
  input  logic              clr_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  output logic              link_bit_o,
  output logic [ADDR_W-1:0] link_addr_o
);

  logic              bit_q;
  logic [ADDR_W-1:0] addr_q;
  logic              kill;

`ifdef LLSC_SNOOP_EN
  // A snoop also hits the word being linked on this very edge.
  assign kill = snoop_valid_i &&
    ((snoop_addr_i[ADDR_W-1:2] == addr_q[ADDR_W-1:2]) ||
     (set_i && snoop_addr_i[ADDR_W-1:2] == set_addr_i[ADDR_W-1:2]));
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      if (clr_i || kill) bit_q <= 1'b0;
      else if (set_i)    bit_q <= 1'b1;
      if (set_i) addr_q <= set_addr_i;
    end
  end

  assign link_bit_o  = bit_q;
  assign link_addr_o = addr_q;

endmodule

// File: rtl/llsc_unit.sv
// Load-linked / store-conditional unit for the memory stage.
// Optional external-write snooping under LLSC_SNOOP_EN.
module llsc_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_sc,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              excpt,
`ifdef LLSC_SNOOP_EN
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
`endif
  output logic              link_bit,
  output logic [ADDR_W-1:0] link_addr
);

  llsc_state_e       state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;
  logic              flushed_q;

  logic              accept;
  logic              intact;
  logic              sc_fail;
  logic              ll_set;
  logic              link_clr;
  logic [ADDR_W-1:0] op_word;

  assign op_word  = ADDR_W'(word_addr(MAX_ADDR_W'(op_addr)));
  assign op_ready = (state_q == IDLE) && !excpt;
  assign accept   = op_valid && op_ready;
  assign intact   = link_bit &&
    (op_addr[ADDR_W-1:2] == link_addr[ADDR_W-1:2]);
  assign sc_fail  = accept && op_is_sc && !intact;
  assign ll_set   = (state_q == LL_MEM) && mem_ack && !flushed_q;
  assign link_clr = excpt || sc_fail ||
    ((state_q == SC_MEM) && mem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (!op_is_sc) begin
              state_q <= LL_MEM;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= op_word;
            end else if (intact) begin
              state_q <= SC_MEM;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= op_word;
              wdata_q <= op_wdata;
            end else begin
              state_q <= RESP;
              data_q  <= DATA_W'(SC_FAIL);
            end
          end
        end
        LL_MEM, SC_MEM: begin
          flushed_q <= flushed_q || excpt;
          if (mem_ack) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            flushed_q <= 1'b0;
            // A flushed op still drains the bus but produces no result.
            if (flushed_q || excpt) begin
              state_q <= IDLE;
            end else begin
              state_q <= RESP;
              data_q  <= (state_q == LL_MEM) ? mem_rdata
                                              : DATA_W'(SC_SUCCESS);
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign res_valid = (state_q == RESP) && !excpt;
  assign res_data  = data_q;

  link_reg #(.ADDR_W(ADDR_W)) u_link (
    .clk         (clk),
    .rst         (rst),
`ifdef LLSC_SNOOP_EN
    .snoop_valid_i(snoop_valid),
    .snoop_addr_i (snoop_addr),
`endif
    .clr_i       (link_clr),
    .set_i       (ll_set),
    .set_addr_i  (addr_q),
    .link_bit_o  (link_bit),
    .link_addr_o (link_addr)
  );

endmodule

// File: tb/tb_llsc_unit.sv
// Directed bench for llsc_unit with a cycle-counting memory responder.
// Snoop scenarios are compiled only under LLSC_SNOOP_EN.
module tb_llsc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_is_sc = 1'b0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        excpt = 1'b0;
`ifdef LLSC_SNOOP_EN
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
`endif
  logic        link_bit;
  logic [31:0] link_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  llsc_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_is_sc   (op_is_sc),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .excpt      (excpt),
`ifdef LLSC_SNOOP_EN
    .snoop_valid(snoop_valid),
    .snoop_addr (snoop_addr),
`endif
    .link_bit   (link_bit),
    .link_addr  (link_addr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, then watch 12 cycles acking after wn request cycles.
  task automatic run_op(
    input  logic        sc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          wn,
    input  logic [31:0] rd,
    input  logic        exc,
    output int          lat,
    output logic [31:0] data,
    output int          nreq,
    output int          nres,
    output logic [31:0] raddr,
    output logic [31:0] rwd,
    output logic        rwe,
    output int          unstable
  );
    lat = -1; data = '0; nreq = 0; nres = 0;
    raddr = '0; rwd = '0; rwe = 1'b0; unstable = 0;
    @(negedge clk);
    check("accept_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_is_sc = sc; op_addr = addr; op_wdata = wd;
    @(negedge clk);
    op_valid = 1'b0; op_addr = 32'hFFFF_FFFF; op_wdata = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      mem_ack = 1'b0;
      excpt = 1'b0;
      if (mem_req) begin
        if (nreq == 0) begin
          raddr = mem_addr; rwd = mem_wdata; rwe = mem_we;
          if (exc) excpt = 1'b1;
        end else if (mem_addr !== raddr || mem_wdata !== rwd ||
                     mem_we !== rwe) begin
          unstable++;
        end
        if (nreq == wn) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        nreq++;
      end
      if (res_valid) begin
        nres++;
        if (lat < 0) begin
          lat = cyc;
          data = res_data;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    excpt = 1'b0;
  endtask

  int          lat, nreq, nres, unst;
  logic [31:0] data, raddr, rwd;
  logic        rwe;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rvalid", 32'(res_valid), 32'd0);
    check("rst_rdata", res_data, 32'd0);
    check("rst_link", 32'(link_bit), 32'd0);
    check("rst_laddr", link_addr, 32'd0);
    rst = 1'b0;

    // ll with two wait cycles
    run_op(1'b0, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("ll_lat", 32'(lat), 32'd4);
    check("ll_data", data, 32'hDEAD_BEEF);
    check("ll_nres", 32'(nres), 32'd1);
    check("ll_nreq", 32'(nreq), 32'd3);
    check("ll_maddr", raddr, 32'h0000_1004);
    check("ll_we", 32'(rwe), 32'd0);
    check("ll_stable", 32'(unst), 32'd0);
    check("ll_link", 32'(link_bit), 32'd1);
    check("ll_laddr", link_addr, 32'h0000_1004);
    check("ll_rhold", res_data, 32'hDEAD_BEEF);

    // sc to another byte of the linked word succeeds
    run_op(1'b1, 32'h0000_1006, 32'h1234_5678, 0, 32'h0, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("sc_maddr", raddr, 32'h0000_1004);
    check("sc_wdata", rwd, 32'h1234_5678);
    check("sc_we", 32'(rwe), 32'd1);
    check("sc_nreq", 32'(nreq), 32'd1);
    check("sc_lat", 32'(lat), 32'd2);
    check("sc_data", data, 32'd1);
    check("sc_link", 32'(link_bit), 32'd0);

    // sc with no link
    run_op(1'b1, 32'h0000_1004, 32'h5555_AAAA, 0, 32'h0, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("scn_nreq", 32'(nreq), 32'd0);
    check("scn_lat", 32'(lat), 32'd1);
    check("scn_data", data, 32'd0);
    check("scn_nres", 32'(nres), 32'd1);

    // ll 0x100 then sc to a different word
    run_op(1'b0, 32'h0000_0100, 32'h0, 0, 32'hA5A5_5A5A, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("ll2_lat", 32'(lat), 32'd2);
    check("ll2_data", data, 32'hA5A5_5A5A);
    check("ll2_laddr", link_addr, 32'h0000_0100);
    run_op(1'b1, 32'h0000_0200, 32'h1, 0, 32'h0, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("scw_nreq", 32'(nreq), 32'd0);
    check("scw_data", data, 32'd0);
    check("scw_link", 32'(link_bit), 32'd0);

    // excpt in IDLE blocks accept and breaks the link
    run_op(1'b0, 32'h0000_0300, 32'h0, 0, 32'h1111_2222, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("ll3_link", 32'(link_bit), 32'd1);
    @(negedge clk);
    excpt = 1'b1;
    op_valid = 1'b1; op_is_sc = 1'b0; op_addr = 32'h0000_0300;
    #1;
    check("exc_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    excpt = 1'b0; op_valid = 1'b0;
    check("exc_noreq", 32'(mem_req), 32'd0);
    check("exc_link", 32'(link_bit), 32'd0);

    // excpt during LL_MEM: drains, no result, no link
    run_op(1'b0, 32'h0000_0300, 32'h0, 2, 32'h3333_4444, 1'b1,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("llx_nreq", 32'(nreq), 32'd3);
    check("llx_stable", 32'(unst), 32'd0);
    check("llx_nres", 32'(nres), 32'd0);
    check("llx_link", 32'(link_bit), 32'd0);
    check("llx_rhold", res_data, 32'h1111_2222);
    run_op(1'b1, 32'h0000_0300, 32'h9, 0, 32'h0, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("scx_nreq", 32'(nreq), 32'd0);
    check("scx_data", data, 32'd0);

`ifdef LLSC_SNOOP_EN
    run_op(1'b0, 32'h0000_0040, 32'h0, 0, 32'h7777_8888, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = 32'h0000_0044;
    @(negedge clk);
    check("snp_miss", 32'(link_bit), 32'd1);
    snoop_addr = 32'h0000_0043;
    @(negedge clk);
    snoop_valid = 1'b0;
    check("snp_hit", 32'(link_bit), 32'd0);
    run_op(1'b1, 32'h0000_0040, 32'h2, 0, 32'h0, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    check("snp_sc_data", data, 32'd0);
    check("snp_sc_nreq", 32'(nreq), 32'd0);
`endif

    // reset while an sc store is outstanding
    run_op(1'b0, 32'h0000_0500, 32'h0, 0, 32'hCAFE_F00D, 1'b0,
           lat, data, nreq, nres, raddr, rwd, rwe, unst);
    @(negedge clk);
    op_valid = 1'b1; op_is_sc = 1'b1; op_addr = 32'h0000_0500;
    op_wdata = 32'hBEEF_0001;
    @(negedge clk);
    op_valid = 1'b0;
    check("mid_req", 32'(mem_req), 32'd1);
    check("mid_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_rdata", res_data, 32'd0);
    check("mid_rst_link", 32'(link_bit), 32'd0);
    check("mid_rst_laddr", link_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_ready", 32'(op_ready), 32'd1);
    check("post_rvalid", 32'(res_valid), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/llsc_unit.md
# llsc_unit

Load-linked / store-conditional execution unit for the CPU's memory stage. It owns the link state, meaning the link bit plus the word address of the link. It issues the memory load for `ll` and sets the link. For `sc`, it checks the link, issues the store only when the link is intact, and returns the success flag that the pipeline writes back into `rt`. Exceptions, and external writes to the linked word when snooping is compiled in, break the link.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: rst, synchronous, active-high; clock clk.
- `op_valid`  in  1  ll/sc request from EX.
- `op_ready`  out  1  unit can accept a request this cycle.
- `op_is_sc`  in  1  request type: 1 = sc, 0 = ll.
- `op_addr`  in  ADDR_W  byte address. Bits [1:0] are ignored (word ops only).
- `op_wdata`  in  DATA_W  sc store data.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  DATA_W  store data.
- `mem_ack`  in  1  memory completion. Valid only while `mem_req` = 1.
- `mem_rdata`  in  DATA_W  load data. Valid with `mem_ack`.
- `res_valid`  out  1  result strobe, one cycle wide.
- `res_data`  out  DATA_W  ll: loaded word; sc: 1 on success, 0 on failure.
- `excpt`  in  1  exception/eret flush.
- `snoop_valid`  in  1  external write observed (only under `LLSC_SNOOP_EN`).
- `snoop_addr`  in  ADDR_W  address of that write (only under `LLSC_SNOOP_EN`).
- `link_bit`  out  1  current link state.
- `link_addr`  out  ADDR_W  linked word address.

## Operation
- FSM states:
  - IDLE: `op_ready = !excpt`.
  - LL_MEM: `mem_req = 1`, `mem_we = 0`.
  - SC_MEM: `mem_req = 1`, `mem_we = 1`.
  - RESP: `res_valid = 1`.
- Request capture: a request is accepted when `op_valid && op_ready`. The unit latches type, address and wdata on that edge.
- ll: IDLE → LL_MEM. On `mem_ack`, latch `mem_rdata`, set `link_bit = 1`, set `link_addr = {op_addr[ADDR_W-1:2], 2'b00}`, then go to RESP.
- sc, link intact: intact means `link_bit = 1` and `op_addr[ADDR_W-1:2]` equals `link_addr[ADDR_W-1:2]`, evaluated at accept. IDLE → SC_MEM. On `mem_ack`: `res_data = 1`, clear `link_bit`, go to RESP.
- sc, link broken: IDLE → RESP directly with `res_data = 0` and `link_bit` cleared. No memory request is issued.
- RESP → IDLE after one cycle.
- Request handshake: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable from assertion until the ack cycle. `mem_req` deasserts on the cycle after ack.
- `excpt` asserted in any state:
  - Clears `link_bit` at the next edge.
  - In IDLE it blocks acceptance.
  - In LL_MEM or SC_MEM the outstanding request is not dropped. It completes to `mem_ack`, then the FSM returns to IDLE with `res_valid` suppressed. A "flushed" flag records the exception until the ack arrives.
  - In RESP, `res_valid` is forced to 0.
- Priority for `link_bit` on a single edge, highest first: reset, excpt, snoop hit, ll completion set.
- `res_data` holds its last value when `res_valid` = 0.

## Timing
- Reset values: `op_ready = 1` (once `rst` falls), `mem_req = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`, `res_valid = 0`, `res_data = 0`, `link_bit = 0`, `link_addr = 0`. FSM is in IDLE.
- Reset in the middle of a transaction: all state is discarded and nothing completes.
- `mem_req` rises 1 cycle after accept.
- Latency for ll, or for sc that performs the store: accept edge + 1 cycle to `mem_req` + N wait cycles to `mem_ack` + 1 cycle to `res_valid`. With ack in the first request cycle, `res_valid` is 2 cycles after accept.
- Failing sc: `res_valid` is 1 cycle after accept.
- Throughput: one op in flight at a time. The next accept is possible in the cycle after RESP.

## Configuration
- `LLSC_SNOOP_EN` defined:
  - A snoop hit is `snoop_valid` with `snoop_addr[ADDR_W-1:2]` equal to `link_addr[ADDR_W-1:2]`. It clears `link_bit` at the next edge.
  - A snoop hit in the same cycle as ll `mem_ack` to the same word leaves `link_bit = 0`.
  - A snoop during SC_MEM does not change the sc result.
- `LLSC_SNOOP_EN` undefined: the snoop ports are absent and only excpt and sc clear the link.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state enum (IDLE, LL_MEM, SC_MEM, RESP);
  - the `SC_SUCCESS`/`SC_FAIL` constants;
  - the word-address slice helper.
- Natural sub-module: `link_reg`. It holds `link_bit` and `link_addr`, applies the set/clear priority, and does the snoop compare.

## Test plan
- ll to 0x0000_1004, memory returns 0xDEADBEEF with ack 2 cycles after `mem_req` → `res_valid` 1 cycle later, `res_data` = 0xDEADBEEF, `link_bit` = 1, `link_addr` = 0x0000_1004.
- Same ll, then sc to 0x0000_1006 with wdata 0x12345678 → store request with `mem_addr` = 0x0000_1004, `mem_wdata` = 0x12345678, `res_data` = 1, `link_bit` = 0.
- sc with no prior ll → no `mem_req`, `res_valid` 1 cycle after accept, `res_data` = 0.
- ll to 0x100, then sc to 0x200 → `res_data` = 0, no store, `link_bit` = 0.
- `excpt` pulsed during LL_MEM → request held until ack, no `res_valid`, `link_bit` = 0. The following sc to the same address returns 0.
- `LLSC_SNOOP_EN`: ll to 0x40, snoop to 0x43, then sc to 0x40 → `res_data` = 0. `rst` asserted during SC_MEM → all outputs return to their reset values on the next edge.
